// File: rtl/neuron.sv
// neuron: serial-MAC trainable neuron with logistic (LUT) or ReLU activation and serial backprop.
// Define NEURON_SATURATE_EN to clamp acc/weight/bias updates instead of two's-complement wrap.
module neuron #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 2,
  parameter int RATE       = 1,
  parameter int ACTIVATION = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     train,
  input  logic                     input_forward_valid,
  input  logic [DEPTH*WIDTH-1:0]   input_forward_data,
  output logic                     input_forward_ready,
  input  logic                     input_backward_valid,
  input  logic [2*WIDTH-1:0]       input_backward_data,
  output logic                     input_backward_ready,
  output logic                     output_backward_valid,
  output logic [DEPTH*2*WIDTH-1:0] output_backward_data,
  input  logic                     output_backward_ready,
  output logic                     output_forward_valid,
  output logic [WIDTH-1:0]         output_forward_data,
  input  logic                     output_forward_ready
);
  localparam int AW = 2 * WIDTH;
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LN = 1 << (WIDTH + 4);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  localparam logic [2:0] S_IDLE = 3'd0, S_MAC = 3'd1, S_DRN = 3'd2, S_ACT = 3'd3,
                         S_FWD  = 3'd4, S_DEL = 3'd5, S_BWD = 3'd6, S_OUT = 3'd7;

`ifdef NEURON_SATURATE_EN
  localparam logic signed [AW+1:0] MAXV = $signed({3'b000, {(AW-1){1'b1}}});
  localparam logic signed [AW+1:0] MINV = $signed({3'b111, {(AW-1){1'b0}}});
`endif

  logic [2:0]                  state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        train_q, train_d;
  logic [DEPTH-1:0][WIDTH-1:0] x_q, x_d;
  logic signed [AW-1:0]        acc_q, acc_d, prod_q, prod_d, bias_q, bias_d;
  logic signed [AW-1:0]        delta_q, delta_d, fd_q, fd_d;
  logic signed [AW-1:0]        w_q [DEPTH];
  logic signed [AW-1:0]        w_d [DEPTH];
  logic [WIDTH-1:0]            f_q, f_d;
  logic [DEPTH-1:0][AW-1:0]    ob_q, ob_d;
  logic [WIDTH-1:0]            actF;
  logic signed [AW-1:0]        actD;
  logic signed [AW+1:0]        addP, addB;

  // Narrow a widened sum back to AW bits: clamp or wrap depending on build.
  function automatic logic signed [AW-1:0] fit(input logic signed [AW+1:0] v);
`ifdef NEURON_SATURATE_EN
    if (v > MAXV) return MAXV[AW-1:0];
    else if (v < MINV) return MINV[AW-1:0];
    else return v[AW-1:0];
`else
    return v[AW-1:0];
`endif
  endfunction

  function automatic logic signed [AW+1:0] ext(input logic signed [AW-1:0] v);
    return (AW+2)'(v);
  endfunction

  function automatic logic signed [AW-1:0] mulShift(input logic signed [AW-1:0] a,
                                                    input logic signed [AW-1:0] b,
                                                    input int sh);
    logic signed [2*AW-1:0] p;
    p = (a * b) >>> sh;
    return AW'(p);
  endfunction

  function automatic logic signed [AW-1:0] zx(input logic [WIDTH-1:0] v);
    return $signed({{(AW-WIDTH){1'b0}}, v});
  endfunction

  // Elaboration-time logistic table entry; index 0 corresponds to acc = -8.0.
  function automatic logic [AW-1:0] lutEntry(input int idx, input bit deriv);
    real a, s;
    int  v;
    a = real'(idx - (LN / 2)) / real'(1 << WIDTH);
    s = 1.0 / (1.0 + $exp(-a));
    if (deriv) v = $rtoi(real'(1 << WIDTH) * s * (1.0 - s));
    else       v = $rtoi(real'(1 << WIDTH) * s);
    if (!deriv && v > (1 << WIDTH) - 1) v = (1 << WIDTH) - 1;
    return AW'(v);
  endfunction

  if (ACTIVATION == 0) begin : gLogistic
    localparam logic signed [AW-1:0] LO = AW'(-(LN / 2));
    localparam logic signed [AW-1:0] HI = AW'((LN / 2) - 1);
    logic [WIDTH-1:0] romF [LN];
    logic [AW-1:0]    romD [LN];
    logic [WIDTH+3:0] idx;
    for (genvar g = 0; g < LN; g++) begin : gRom
      localparam logic [AW-1:0] FV = lutEntry(g, 1'b0);
      localparam logic [AW-1:0] DV = lutEntry(g, 1'b1);
      assign romF[g] = FV[WIDTH-1:0];
      assign romD[g] = DV;
    end
    // Clamp to [-8,8) then offset by +8.0 (MSB flip of the in-range two's-complement value).
    always_comb begin
      if (acc_q < LO)      idx = '0;
      else if (acc_q > HI) idx = '1;
      else                 idx = acc_q[WIDTH+3:0] ^ {1'b1, {(WIDTH+3){1'b0}}};
    end
    assign actF = romF[idx];
    assign actD = $signed(romD[idx]);
  end else begin : gRelu
    localparam logic signed [AW-1:0] MAXF = AW'((1 << WIDTH) - 1);
    always_comb begin
      if (acc_q[AW-1])       actF = '0;
      else if (acc_q > MAXF) actF = '1;
      else                   actF = acc_q[WIDTH-1:0];
      actD = (!acc_q[AW-1] && (acc_q != '0)) ? AW'(1 << WIDTH) : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    train_d = train_q;
    x_d     = x_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    bias_d  = bias_q;
    delta_d = delta_q;
    fd_d    = fd_q;
    f_d     = f_q;
    ob_d    = ob_q;
    w_d     = w_q;
    addP    = '0;
    addB    = '0;
    case (state_q)
      S_IDLE: if (input_forward_valid) begin
        x_d     = input_forward_data;
        train_d = train;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = S_MAC;
      end
      // Product is registered, so it is folded into acc one cycle later (and in DRN for the last one).
      S_MAC: begin
        prod_d = mulShift(w_q[cnt_q], zx(x_q[cnt_q]), WIDTH);
        if (cnt_q != '0) addP = ext(prod_q);
        if (cnt_q == LAST) addB = ext(bias_q);
        acc_d = fit(ext(acc_q) + addP + addB);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_DRN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRN: begin
        acc_d   = fit(ext(acc_q) + ext(prod_q));
        state_d = S_ACT;
      end
      S_ACT: begin
        f_d     = actF;
        fd_d    = actD;
        state_d = S_FWD;
      end
      S_FWD: if (output_forward_ready) state_d = train_q ? S_DEL : S_IDLE;
      S_DEL: if (input_backward_valid) begin
        delta_d = mulShift($signed(input_backward_data), fd_q, WIDTH);
        cnt_d   = '0;
        state_d = S_BWD;
      end
      S_BWD: begin
        ob_d[cnt_q] = mulShift(w_q[cnt_q], delta_q, WIDTH);
        w_d[cnt_q]  = fit(ext(w_q[cnt_q]) + ext(mulShift(delta_q, zx(x_q[cnt_q]), RATE + WIDTH)));
        if (cnt_q == LAST) begin
          bias_d  = fit(ext(bias_q) + ext(delta_q >>> RATE));
          cnt_d   = '0;
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OUT: if (output_backward_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      train_q <= 1'b0;
      x_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      bias_q  <= '0;
      delta_q <= '0;
      fd_q    <= '0;
      f_q     <= '0;
      ob_q    <= '0;
      for (int i = 0; i < DEPTH; i++) w_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      train_q <= train_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      bias_q  <= bias_d;
      delta_q <= delta_d;
      fd_q    <= fd_d;
      f_q     <= f_d;
      ob_q    <= ob_d;
      for (int i = 0; i < DEPTH; i++) w_q[i] <= w_d[i];
    end
  end

  assign input_forward_ready   = (state_q == S_IDLE);
  assign input_backward_ready  = (state_q == S_DEL);
  assign output_forward_valid  = (state_q == S_FWD);
  assign output_backward_valid = (state_q == S_OUT);
  assign output_forward_data   = f_q;
  assign output_backward_data  = ob_q;

endmodule

// File: tb/tb_neuron.sv
// tb_neuron: logistic and ReLU neurons driven in lockstep, checked against an arithmetic reference model.
module tb_neuron;
  localparam int W = 8;
  localparam int D = 2;
  localparam int R = 1;

  logic clock = 1'b0;
  logic reset, train, ifv, ibv, obr, ofr;
  logic [D*W-1:0] ifd;
  logic [2*W-1:0] ibd;
  logic ifrL, ibrL, obvL, ofvL, ifrR, ibrR, obvR, ofvR;
  logic [D*2*W-1:0] obdL, obdR;
  logic [W-1:0] ofdL, ofdR;

  int checks = 0;
  int errors = 0;
  longint wM [2][D];
  longint bM [2];
  longint lastFL, lastFR;
  longint lastObL [D];
  longint lastObR [D];

  always #5 clock = ~clock;

  neuron #(.WIDTH(W), .DEPTH(D), .RATE(R), .ACTIVATION(0)) dutL (
    .clock(clock), .reset(reset), .train(train),
    .input_forward_valid(ifv), .input_forward_data(ifd), .input_forward_ready(ifrL),
    .input_backward_valid(ibv), .input_backward_data(ibd), .input_backward_ready(ibrL),
    .output_backward_valid(obvL), .output_backward_data(obdL), .output_backward_ready(obr),
    .output_forward_valid(ofvL), .output_forward_data(ofdL), .output_forward_ready(ofr));

  neuron #(.WIDTH(W), .DEPTH(D), .RATE(R), .ACTIVATION(1)) dutR (
    .clock(clock), .reset(reset), .train(train),
    .input_forward_valid(ifv), .input_forward_data(ifd), .input_forward_ready(ifrR),
    .input_backward_valid(ibv), .input_backward_data(ibd), .input_backward_ready(ibrR),
    .output_backward_valid(obvR), .output_backward_data(obdR), .output_backward_ready(obr),
    .output_forward_valid(ofvR), .output_forward_data(ofdR), .output_forward_ready(ofr));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic longint wrap16(input longint v);
    shortint t;
    t = shortint'(v);
    return longint'(t);
  endfunction

  function automatic longint fitv(input longint v);
`ifdef NEURON_SATURATE_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    return wrap16(v);
`endif
  endfunction

  // Weighted sum with bias; products are exact fractions truncated toward -inf by the shift.
  function automatic longint accOf(input int m, input longint x [D]);
    longint acc;
    acc = fitv(((wM[m][0] * x[0]) >>> W) + bM[m]);
    acc = fitv(acc + ((wM[m][1] * x[1]) >>> W));
    return acc;
  endfunction

  function automatic void activate(input longint acc, input bit relu, output longint f, output longint fd);
    real a, s;
    if (relu) begin
      f  = (acc < 0) ? 0 : ((acc > 255) ? 255 : acc);
      fd = (acc > 0) ? 256 : 0;
    end else begin
      a  = real'((acc < -2048) ? -2048 : ((acc > 2047) ? 2047 : acc)) / real'(256);
      s  = 1.0 / (1.0 + $exp(-a));
      f  = longint'($rtoi(256.0 * s));
      if (f > 255) f = 255;
      fd = longint'($rtoi(256.0 * s * (1.0 - s)));
    end
  endfunction

  task automatic resetDut();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int m = 0; m < 2; m++) begin
      bM[m] = 0;
      for (int i = 0; i < D; i++) wM[m][i] = 0;
    end
    checkOutput("rstFwdReady", ifrL & ifrR, 1);
    checkOutput("rstFwdValid", ofvL | ofvR, 0);
    checkOutput("rstBwdValid", obvL | obvR, 0);
    checkOutput("rstBwdReady", ibrL | ibrR, 0);
  endtask

  task automatic applyStimulus(input longint x [D], input bit trainBit, input longint err,
                               input int holdF, input int holdB, input bit resetInBwd);
    int n;
    longint acc, delta;
    longint f [2];
    longint fd [2];
    longint ob [2][D];
    for (int m = 0; m < 2; m++) begin
      acc = accOf(m, x);
      activate(acc, m == 1, f[m], fd[m]);
    end
    n = 0;
    while (!(ifrL && ifrR) && n < 20) begin tick(); n++; end
    checkOutput("fwdReadyIdle", ifrL & ifrR, 1);
    ifv = 1'b1;
    ifd = {W'(x[1]), W'(x[0])};
    train = trainBit;
    tick();
    ifv = 1'b0;
    ifd = D*W'($urandom);
    train = 1'($urandom);
    n = 0;
    while (!ofvL && n < 20) begin tick(); n++; end
    checkOutput("fwdLatency", n, D + 2);
    checkOutput("fwdValidR", ofvR, 1);
    checkOutput("fwdDataL", ofdL, f[0]);
    checkOutput("fwdDataR", ofdR, f[1]);
    lastFL = ofdL;
    lastFR = ofdR;
    for (int c = 0; c < holdF; c++) begin
      ifv = 1'b1;
      ibv = 1'b1;
      ibd = 16'($urandom);
      tick();
      checkOutput("holdValid", ofvL & ofvR, 1);
      checkOutput("holdDataL", ofdL, f[0]);
      checkOutput("holdNoAccept", ifrL | ifrR, 0);
    end
    ifv = 1'b0;
    ibv = 1'b0;
    ofr = 1'b1;
    tick();
    ofr = 1'b0;
    checkOutput("fwdDrop", ofvL | ofvR, 0);
    if (!trainBit) begin
      checkOutput("readyBack", ifrL & ifrR, 1);
      return;
    end
    checkOutput("bwdReady", ibrL & ibrR, 1);
    for (int m = 0; m < 2; m++) begin
      delta = fitv((err * fd[m]) >>> W);
      for (int i = 0; i < D; i++) begin
        ob[m][i] = wrap16((wM[m][i] * delta) >>> W);
        wM[m][i] = fitv(wM[m][i] + ((delta * x[i]) >>> (R + W)));
      end
      bM[m] = fitv(bM[m] + (delta >>> R));
    end
    ibv = 1'b1;
    ibd = 16'(err);
    tick();
    ibv = 1'b0;
    ibd = 16'($urandom);
    if (resetInBwd) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int m = 0; m < 2; m++) begin
        bM[m] = 0;
        for (int i = 0; i < D; i++) wM[m][i] = 0;
      end
      checkOutput("midRstIdle", ifrL & ifrR, 1);
      checkOutput("midRstValids", obvL | ofvL | obvR | ofvR, 0);
      checkOutput("midRstW0", dutL.w_q[0], 0);
      checkOutput("midRstBias", dutL.bias_q, 0);
      return;
    end
    n = 0;
    while (!obvL && n < 20) begin tick(); n++; end
    checkOutput("bwdLatency", n, D);
    checkOutput("bwdValidR", obvR, 1);
    for (int i = 0; i < D; i++) begin
      lastObL[i] = $signed(obdL[i*2*W +: 2*W]);
      lastObR[i] = $signed(obdR[i*2*W +: 2*W]);
      checkOutput("bwdDataL", lastObL[i], ob[0][i]);
      checkOutput("bwdDataR", lastObR[i], ob[1][i]);
    end
    for (int c = 0; c < holdB; c++) begin
      tick();
      checkOutput("bwdHold", obvL & obvR, 1);
    end
    obr = 1'b1;
    tick();
    obr = 1'b0;
    checkOutput("bwdDrop", obvL | obvR, 0);
    checkOutput("bwdIdle", ifrL & ifrR, 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    longint x [D];
    reset = 1'b1; train = 1'b0; ifv = 1'b0; ibv = 1'b0; obr = 1'b0; ofr = 1'b0;
    ifd = '0; ibd = '0;
    resetDut();

    $display("[TB] logistic forward, then one training step");
    x[0] = 128; x[1] = 64;
    applyStimulus(x, 1'b0, 0, 0, 0, 1'b0);
    checkOutput("t1Fwd", lastFL, 128);
    applyStimulus(x, 1'b1, 256, 0, 0, 1'b0);
    checkOutput("t2ObL0", lastObL[0], 0);
    checkOutput("t2ObL1", lastObL[1], 0);
    checkOutput("t2W0", dutL.w_q[0], 16);
    checkOutput("t2W1", dutL.w_q[1], 8);
    checkOutput("t2Bias", dutL.bias_q, 32);
    applyStimulus(x, 1'b0, 0, 0, 0, 1'b0);
    checkOutput("t2Fwd", lastFL, 138);

    $display("[TB] ReLU at zero weights does not learn");
    resetDut();
    x[0] = 255; x[1] = 255;
    applyStimulus(x, 1'b1, 256, 0, 0, 1'b0);
    checkOutput("t3Fwd", lastFR, 0);
    checkOutput("t3Ob0", lastObR[0], 0);
    checkOutput("t3W0", dutR.w_q[0], 0);
    checkOutput("t3Bias", dutR.bias_q, 0);

    $display("[TB] forward backpressure");
    x[0] = 77; x[1] = 200;
    applyStimulus(x, 1'b1, -1000, 10, 3, 1'b0);

    $display("[TB] reset during backward pass");
    x[0] = 128; x[1] = 64;
    applyStimulus(x, 1'b1, 256, 0, 0, 1'b1);
    applyStimulus(x, 1'b0, 0, 0, 0, 1'b0);
    checkOutput("t5Fwd", lastFL, 128);

    $display("[TB] randomized samples");
    for (int s = 0; s < 40; s++) begin
      x[0] = $urandom_range(0, 255);
      x[1] = $urandom_range(0, 255);
      applyStimulus(x, 1'($urandom), longint'($signed(16'($urandom))),
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    $display("[TB] long training run");
    resetDut();
    x[0] = 255; x[1] = 255;
    for (int s = 0; s < 300; s++) applyStimulus(x, 1'b1, 32767, 0, 0, 1'b0);
    checkOutput("t6BiasL", dutL.bias_q, bM[0]);
    checkOutput("t6W0L", dutL.w_q[0], wM[0][0]);
    checkOutput("t6BiasR", dutR.bias_q, bM[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
